// File: rtl/fault_test_pkg.sv
// Shared constants, test-vector table, FSM state type and result payload for fault_test_sequencer.
package fault_test_pkg;

   localparam int unsigned NUM_VEC       = 7;
   localparam int unsigned IN_W          = 4;
   localparam int unsigned SETTLE_CYCLES = 2;

   localparam int unsigned CNT_W = $clog2(NUM_VEC + 1);
   localparam int unsigned IDX_W = $clog2(NUM_VEC);
   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

   // Element k is vector k, ordered {a,b,c,d}
   localparam logic [NUM_VEC-1:0][IN_W-1:0] TEST_VEC = {
      4'b1100, 4'b1000, 4'b0100, 4'b0011, 4'b0010, 4'b0001, 4'b0000
   };

   // Bit k is the golden response to vector k
   localparam logic [NUM_VEC-1:0] EXPECTED = 7'b1001011;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      COMPARE,
      DONE
   } seq_state_e;

   typedef struct packed {
      logic [NUM_VEC-1:0] mask;
      logic [CNT_W-1:0]   count;
      logic [IDX_W-1:0]   first_idx;
   } fault_result_t;

endpackage

// File: rtl/fault_test_sequencer_if.sv
// Test-controller / CUT signal bundle for fault_test_sequencer.
interface fault_test_sequencer_if;
   import fault_test_pkg::*;

   logic               start;
   logic [IN_W-1:0]    cut_in;
   logic               cut_out;
   logic               busy;
   logic               done;
   logic               pass;
   logic [NUM_VEC-1:0] fail_mask;
   logic [CNT_W-1:0]   fail_count;
   logic [IDX_W-1:0]   first_fail_idx;

   // Tester side: issues start and returns the CUT response
   modport master (
      output start, cut_out,
      input  cut_in, busy, done, pass, fail_mask, fail_count, first_fail_idx
   );

   modport slave (
      input  start, cut_out,
      output cut_in, busy, done, pass, fail_mask, fail_count, first_fail_idx
   );

endinterface

// File: rtl/fault_test_sequencer_accum.sv
// fault_result_accum: failure mask / count / first-failing-index register bank.
module fault_result_accum
   import fault_test_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             mis_i,
   input  logic [IDX_W-1:0] idx_i,
   output fault_result_t    res_o
);

   fault_result_t res_q, res_d;

   always_comb begin
      res_d = res_q;
      if (clr_i) begin
         res_d = '0;
      end else if (mis_i) begin
         res_d.mask[idx_i] = 1'b1;
         res_d.count       = res_q.count + CNT_W'(1);
         if (res_q.count == '0) res_d.first_idx = idx_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) res_q <= '0;
      else        res_q <= res_d;
   end

   assign res_o = res_q;

endmodule

// File: rtl/fault_test_sequencer.sv
// Applies the stuck-at vector table to the CUT and records mismatches.
// Build option FAULT_SEQ_ABORT_ON_FAIL_EN ends the run at the first mismatch.
module fault_test_sequencer
   import fault_test_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   fault_test_sequencer_if.slave  bus
);

   seq_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [IN_W-1:0]  cut_in_q, cut_in_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             clr_c;
   logic             mis_c;
   logic             end_c;
   fault_result_t    res;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      cut_in_d = cut_in_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      clr_c    = 1'b0;
      mis_c    = (state_q == COMPARE) && (bus.cut_out != EXPECTED[idx_q]);
`ifdef FAULT_SEQ_ABORT_ON_FAIL_EN
      end_c    = (idx_q == IDX_W'(NUM_VEC - 1)) || mis_c;
`else
      end_c    = (idx_q == IDX_W'(NUM_VEC - 1));
`endif

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               clr_c    = 1'b1;
               idx_d    = '0;
               settle_d = '0;
               cut_in_d = TEST_VEC[0];
               busy_d   = 1'b1;
               pass_d   = 1'b0;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            settle_d = settle_q + SET_W'(1);
            if (settle_d == SET_W'(SETTLE_CYCLES)) state_d = COMPARE;
         end
         COMPARE: begin
            // pass must include this edge's mismatch, which the accumulator has not yet absorbed
            if (end_c) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (res.count == '0) && !mis_c;
               state_d = DONE;
            end else begin
               idx_d    = idx_q + IDX_W'(1);
               cut_in_d = TEST_VEC[idx_d];
               settle_d = '0;
               state_d  = SETTLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         cut_in_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         cut_in_q <= cut_in_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   fault_result_accum u_accum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr_c),
      .mis_i (mis_c),
      .idx_i (idx_q),
      .res_o (res)
   );

   assign bus.cut_in         = cut_in_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.fail_mask      = res.mask;
   assign bus.fail_count     = res.count;
   assign bus.first_fail_idx = res.first_idx;

endmodule
